// File: rtl/cve2_pkg.sv
// Shared types for the iterative multiply/divide unit: operator encoding,
// FSM states and the iteration counter width.
package cve2_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  localparam int MD_ITER_CNT_W = 5;

endpackage

// File: rtl/cve2_md_addsub.sv
// 33-bit adder/subtractor with carry-in and carry-out; a carry-out of 1 on a
// subtract means a >= b (no borrow).
module cve2_md_addsub (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  input  logic        cin,
  output logic [32:0] sum,
  output logic        carry
);

  logic [32:0] b_eff;

  assign b_eff        = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {33'd0, cin};

endmodule

// File: rtl/cve2_md_iter_unit.sv
// Iterative radix-2 multiply / restoring divide unit, one bit per cycle.
// Optional macro CVE2_MD_EARLY_TERM_EN short-cuts multiplies by zero.
module cve2_md_iter_unit
  import cve2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  md_state_e                state_q, state_d;
  md_op_e                   op_q, op_in;
  logic [MD_ITER_CNT_W-1:0] cnt_q;
  logic [63:0]              acc_q, acc_next;
  logic [31:0]              opnd_q;
  logic                     neg_q;
  logic [31:0]              result_q;

  logic        accept, is_div, sign_a, sign_b, div_zero, div_ovf, mul_zero, special;
  logic [31:0] abs_a, abs_b, special_res, field, fix_res;
  logic [32:0] add_a, add_b, sum;
  logic        add_sub, add_cin, carry;

  assign op_in   = md_op_e'(operator_i);
  assign is_div  = operator_i[1];
  assign accept  = valid_i && (state_q == MD_IDLE) && !kill_i;
  assign sign_a  = signed_mode_i[0] & op_a_i[31];
  assign sign_b  = signed_mode_i[1] & op_b_i[31];
  assign abs_a   = sign_a ? 32'd0 - op_a_i : op_a_i;
  assign abs_b   = sign_b ? 32'd0 - op_b_i : op_b_i;

  assign div_zero = is_div && (op_b_i == 32'd0);
  assign div_ovf  = is_div && (signed_mode_i == 2'b11) &&
                    (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
`ifdef CVE2_MD_EARLY_TERM_EN
  assign mul_zero = !is_div && ((op_a_i == 32'd0) || (op_b_i == 32'd0));
`else
  assign mul_zero = 1'b0;
`endif
  assign special  = div_zero || div_ovf || mul_zero;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    special_res = 32'd0;
    if (div_zero)     special_res = (op_in == MD_OP_REM) ? op_a_i : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = (op_in == MD_OP_REM) ? 32'd0 : 32'h8000_0000;
  end

  cve2_md_addsub u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (add_sub),
    .cin   (add_cin),
    .sum   (sum),
    .carry (carry)
  );

  // MULH and REM live in the upper half of the accumulator.
  assign field = ((op_q == MD_OP_MULH) || (op_q == MD_OP_REM)) ? acc_q[63:32] : acc_q[31:0];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    add_cin = 1'b0;
    if (state_q == MD_CALC) begin
      if (op_q[1]) begin
        add_a   = acc_q[63:31];
        add_b   = {1'b0, opnd_q};
        add_sub = 1'b1;
        add_cin = 1'b1;
      end else begin
        add_a = {1'b0, acc_q[63:32]};
        add_b = acc_q[0] ? {1'b0, opnd_q} : 33'd0;
      end
    end else if (state_q == MD_FIX) begin
      // Upper half of a negated 64-bit product: ~hi plus the carry out of -lo.
      if (op_q == MD_OP_MULH) begin
        add_a   = {1'b0, ~acc_q[63:32]};
        add_cin = (acc_q[31:0] == 32'd0);
      end else begin
        add_b   = {1'b0, field};
        add_sub = 1'b1;
        add_cin = 1'b1;
      end
    end
  end

  always_comb begin
    acc_next = acc_q;
    if (op_q[1]) acc_next = {carry ? sum[31:0] : acc_q[62:31], acc_q[30:0], carry};
    else         acc_next = {sum, acc_q[31:1]};
    fix_res = neg_q ? sum[31:0] : field;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept) state_d = special ? MD_DONE : MD_CALC;
      MD_CALC: if (kill_i) state_d = MD_IDLE;
               else if (cnt_q == '0) state_d = MD_FIX;
      MD_FIX:  state_d = kill_i ? MD_IDLE : MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) state_q <= MD_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q     <= MD_OP_MULL;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        MD_IDLE: if (accept) begin
          op_q  <= op_in;
          neg_q <= (op_in == MD_OP_REM) ? sign_a : (sign_a ^ sign_b);
          cnt_q <= MD_ITER_CNT_W'(31);
          if (special) begin
            result_q <= special_res;
          end else begin
            opnd_q <= is_div ? abs_b : abs_a;
            acc_q  <= {32'd0, is_div ? abs_a : abs_b};
          end
        end
        MD_CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - MD_ITER_CNT_W'(1);
        end
        MD_FIX:  if (!kill_i) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == MD_IDLE);
  assign valid_o  = (state_q == MD_DONE) && !kill_i;
  assign result_o = result_q;

endmodule
